// File: rtl/pipe_skid_pkg.sv
// Shared definitions for the pipe_skid two-entry skid buffer:
// state encodings and the default data word width.
package pipe_skid_pkg;

  localparam int PIPE_SKID_N = 32;

  typedef enum logic [1:0] {
    PIPE_SKID_EMPTY = 2'd0,
    PIPE_SKID_ONE   = 2'd1,
    PIPE_SKID_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_if.sv
// Handshake bundle for pipe_skid: upstream valid/ready/data in, downstream
// valid/ready/data out. The flush signal exists only when PIPE_SKID_FLUSH_EN
// is defined. slave = the skid buffer's view, master = the surrounding logic.
interface pipe_skid_if #(parameter int N = pipe_skid_pkg::PIPE_SKID_N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
`ifdef PIPE_SKID_FLUSH_EN
  logic         flush;

  modport slave  (input  in_valid, in_data, out_ready, flush,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready, flush,
                  input  in_ready, out_valid, out_data);
`else
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
`endif

endinterface

// File: rtl/pipe_skid_flipflop.sv
// N-bit data register with synchronous active-high reset and write enable.
module pipe_skid_flipflop #(
  parameter int N = pipe_skid_pkg::PIPE_SKID_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  // Load on we; reset clears the word and overrides we.
  always_ff @(posedge clk) begin
    if (reset)   out <= '0;
    else if (we) out <= in;
  end

endmodule

// File: rtl/pipe_skid.sv
// pipe_skid: two-entry elastic pipeline register. Main register drives
// out_data; the skid register absorbs one word while downstream stalls so
// in_ready is purely registered. Optional macro PIPE_SKID_FLUSH_EN adds a
// flush input that empties the buffer without clearing the data registers.
//
// state | meaning
// EMPTY | no word held
// ONE   | main register valid
// TWO   | main and skid registers valid, upstream blocked
module pipe_skid
  import pipe_skid_pkg::*;
#(
  parameter int N = PIPE_SKID_N
) (
  input logic         clk,
  input logic         reset,
  pipe_skid_if.slave  bus
);

  skid_state_t  state;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         acc;
  logic         pop;
  logic         kill;
  logic         main_we;
  logic         skid_we;
  logic [N-1:0] main_d;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;

`ifdef PIPE_SKID_FLUSH_EN
  assign kill = bus.flush;
`else
  assign kill = 1'b0;
`endif

  assign acc = bus.in_valid && in_ready_q;
  assign pop = out_valid_q && bus.out_ready;

  // Data-path write enables and the main register's next value.
  always_comb begin
    main_we = 1'b0;
    skid_we = 1'b0;
    main_d  = bus.in_data;
    if (!kill) begin
      case (state)
        PIPE_SKID_EMPTY: main_we = acc;
        PIPE_SKID_ONE: begin
          main_we = acc && pop;
          skid_we = acc && !pop;
        end
        PIPE_SKID_TWO: begin
          main_we = pop;
          main_d  = skid_q;
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered out_valid / in_ready.
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      state       <= PIPE_SKID_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        PIPE_SKID_EMPTY: begin
          if (acc) begin
            state       <= PIPE_SKID_ONE;
            out_valid_q <= 1'b1;
          end
        end
        PIPE_SKID_ONE: begin
          if (acc && !pop) begin
            state      <= PIPE_SKID_TWO;
            in_ready_q <= 1'b0;
          end else if (pop && !acc) begin
            state       <= PIPE_SKID_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        PIPE_SKID_TWO: begin
          if (pop) begin
            state      <= PIPE_SKID_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= PIPE_SKID_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  pipe_skid_flipflop #(.N(N)) u_main (
    .clk   (clk),
    .reset (reset),
    .we    (main_we),
    .in    (main_d),
    .out   (main_q)
  );

  pipe_skid_flipflop #(.N(N)) u_skid (
    .clk   (clk),
    .reset (reset),
    .we    (skid_we),
    .in    (bus.in_data),
    .out   (skid_q)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid.sv
// Directed bench for pipe_skid: reset, streaming, stall fill, drain,
// simultaneous accept/pop, mid-transfer reset and (when built with
// PIPE_SKID_FLUSH_EN) flush.
module tb_pipe_skid;
  import pipe_skid_pkg::*;

  localparam int N = PIPE_SKID_N;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  pipe_skid_if #(.N(N)) bus ();

  pipe_skid #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic ov, input logic ir);
    chk({tag, "_out_valid"}, {{(N-1){1'b0}}, bus.out_valid}, {{(N-1){1'b0}}, ov});
    chk({tag, "_in_ready"},  {{(N-1){1'b0}}, bus.in_ready},  {{(N-1){1'b0}}, ir});
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 'hAA;
    bus.out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    bus.flush     = 1'b0;
`endif

    // reset held two cycles with a word offered
    tick();
    tick();
    expect_state("rst", 1'b0, 1'b1);
    chk("rst_out_data", bus.out_data, '0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    expect_state("post_rst", 1'b0, 1'b1);

    // streaming at full throughput
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = N'(i);
      tick();
      chk($sformatf("stream_data_%0d", i), bus.out_data, N'(i));
      expect_state($sformatf("stream_%0d", i), 1'b1, 1'b1);
    end
    bus.in_valid = 1'b0;
    tick();
    expect_state("stream_empty", 1'b0, 1'b1);

    // stall fill: 6 and 7 accepted, 8 held upstream
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 'd6;
    tick();
    chk("fill_6", bus.out_data, 'd6);
    expect_state("fill_one", 1'b1, 1'b1);
    bus.in_data = 'd7;
    tick();
    chk("fill_7_head", bus.out_data, 'd6);
    expect_state("fill_two", 1'b1, 1'b0);
    bus.in_data = 'd8;
    tick();
    chk("fill_stable", bus.out_data, 'd6);
    expect_state("fill_hold", 1'b1, 1'b0);

    // drain: 7 then 8, in_ready back after 6 leaves
    bus.out_ready = 1'b1;
    tick();
    chk("drain_7", bus.out_data, 'd7);
    expect_state("drain_a", 1'b1, 1'b1);
    tick();
    chk("drain_8", bus.out_data, 'd8);
    expect_state("drain_b", 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    expect_state("drain_empty", 1'b0, 1'b1);

    // simultaneous accept and pop in ONE
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 'd9;
    tick();
    chk("sim_9", bus.out_data, 'd9);
    bus.in_data   = 'd10;
    bus.out_ready = 1'b1;
    tick();
    chk("sim_10", bus.out_data, 'd10);
    expect_state("sim", 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    expect_state("sim_empty", 1'b0, 1'b1);

    // reset mid-transfer drops contents and ignores the coincident acc/pop
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 'h55;
    tick();
    bus.in_data   = 'h66;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    tick();
    expect_state("mid_rst", 1'b0, 1'b1);
    chk("mid_rst_data", bus.out_data, '0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    expect_state("mid_rst_after", 1'b0, 1'b1);

`ifdef PIPE_SKID_FLUSH_EN
    // flush from TWO discards 11, 12 and the offered 13
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 'd11;
    tick();
    bus.in_data = 'd12;
    tick();
    expect_state("pre_flush", 1'b1, 1'b0);
    bus.flush     = 1'b1;
    bus.in_data   = 'd13;
    bus.out_ready = 1'b1;
    tick();
    expect_state("flush", 1'b0, 1'b1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    expect_state("post_flush", 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 'd14;
    tick();
    chk("flush_next", bus.out_data, 'd14);
    bus.in_valid = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_skid.md
Name: pipe_skid

Overview:
- Two-entry elastic pipeline register (skid buffer) forming the receiving end of a pipeline stage hand-off.
- Accepts words from an upstream stage under a valid/ready handshake and presents them to the downstream stage.
- Absorbs one extra word when downstream stalls, so upstream never sees a combinational ready path.
- Placed between pipeline stages wherever a stage can back-pressure.

Parameters:
- N, 32, data word width in bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream offers in_data this cycle
- in_ready  output  1  buffer can accept a word; registered
- in_data  input  N  upstream word
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  downstream consumes out_data this cycle
- out_data  output  N  head word
- flush  input  1  present only with PIPE_SKID_FLUSH_EN; discard contents

Behaviour:
- Upstream transfer (acc) = in_valid && in_ready. Downstream transfer (pop) = out_valid && out_ready. Both are sampled at the rising edge of clk.
- Storage: main register (head, drives out_data) and skid register.
- States: EMPTY (0 words), ONE (main valid), TWO (main and skid valid). Encoding constants come from the shared header.
- Reset (synchronous, highest priority):
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - out_data = 0, skid register = 0.
  - Reset asserted mid-transfer drops all contents. No acc or pop is honoured in that cycle.
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO). Driven from a register, so there is no combinational path from out_ready to in_ready.
- Transitions:
  - EMPTY, acc -> ONE; main <= in_data.
  - EMPTY, no acc -> EMPTY.
  - ONE, acc && !pop -> TWO; skid <= in_data; main unchanged.
  - ONE, pop && !acc -> EMPTY.
  - ONE, acc && pop -> ONE; main <= in_data. Full throughput.
  - ONE, neither -> ONE; main held.
  - TWO, pop -> ONE; main <= skid. No acc is possible here because in_ready = 0.
  - TWO, no pop -> TWO; all held.
- Latency: a word accepted at edge k is on out_data with out_valid = 1 after edge k.
  - Minimum latency is 1 cycle.
  - Sustained throughput is 1 word/cycle when out_ready stays high.
- Ordering: strict FIFO; no word is ever duplicated or dropped, except on reset or flush.
- Stability: while out_valid && !out_ready, out_data must not change.
- in_data is ignored whenever in_ready = 0, and also while in_valid = 0.
- Widths: all data paths are exactly N bits; no arithmetic.

Optional Feature:
- Macro: PIPE_SKID_FLUSH_EN.
- Defined:
  - flush port exists. flush = 1 at an edge forces state EMPTY, out_valid = 0 and in_ready = 1 after that edge.
  - A coincident acc or pop is discarded, i.e. treated as not having occurred.
  - Data registers keep their stale values.
  - Priority: reset > flush > acc/pop.
- Not defined: no flush port; behaviour is exactly as above.

Decomposition:
- Shared header pipeline_defs.v holds the state encodings (PIPE_SKID_EMPTY = 2'd0, PIPE_SKID_ONE = 2'd1, PIPE_SKID_TWO = 2'd2) and the default width constant.
- The main and skid data registers are instances of the existing flipflop module (N-bit, clk/reset/we/in/out).
  - we is derived from the transition logic.
  - reset is tied to reset. With PIPE_SKID_FLUSH_EN defined, flush is not OR'd into it, so data is not cleared on flush.
- Control FSM is inline; no further sub-module.

Test Plan:
- Reset: hold reset 2 cycles with in_valid = 1, in_data = 8'hAA -> out_valid = 0, in_ready = 1, out_data = 0; nothing accepted.
- Streaming: out_ready = 1, send 1, 2, 3, 4, 5 on consecutive cycles -> out_data = 1..5 on consecutive cycles, each 1 cycle after acceptance; in_ready stays 1.
- Stall fill: out_ready = 0, send 6, 7, 8 back-to-back -> 6 and 7 accepted, in_ready = 0 after the second acceptance, 8 held upstream; out_data = 6, stable.
- Drain: from that state raise out_ready -> out_data = 6, 7, 8 in order; in_ready returns to 1 the cycle after 6 is popped; no loss or duplication.
- Simultaneous: state ONE holding 9, acc of 10 and pop in same cycle -> state ONE, out_data = 10 next cycle, in_ready = 1.
- Flush (PIPE_SKID_FLUSH_EN): state TWO holding 11, 12; assert flush with in_valid = 1, out_ready = 1 -> next cycle out_valid = 0, in_ready = 1; 11, 12 and the offered word never appear at out_data.
